// File: rtl/rs_age_issue.sv
// Age-matrix reservation station: WAYS-wide dispatch with CDB bypass/wakeup, ISSUE_W oldest-first issue ports.
// Issue is combinational from registered state (dispatch at edge k -> issue in k+1); a stalled port holds its entry.
module rs_age_issue #(
  parameter int XLEN      = 32,
  parameter int PRF       = 64,
  parameter int ROB       = 16,
  parameter int RS_SIZE   = 16,
  parameter int WAYS      = 3,
  parameter int CDB_W     = 3,
  parameter int ISSUE_W   = 3,
  parameter int PAYLOAD_W = 64
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [WAYS-1:0]                        dispatch_valid,
  input  logic [WAYS*XLEN-1:0]                   opa_in,
  input  logic [WAYS*XLEN-1:0]                   opb_in,
  input  logic [WAYS-1:0]                        opa_ready_in,
  input  logic [WAYS-1:0]                        opb_ready_in,
  input  logic [WAYS*$clog2(PRF)-1:0]            dest_prf_in,
  input  logic [WAYS*$clog2(ROB)-1:0]            rob_idx_in,
  input  logic [WAYS*PAYLOAD_W-1:0]              payload_in,
  input  logic [CDB_W-1:0]                       cdb_valid,
  input  logic [CDB_W*$clog2(PRF)-1:0]           cdb_prf_idx,
  input  logic [CDB_W*XLEN-1:0]                  cdb_data,
  input  logic [ISSUE_W-1:0]                     issue_ready,
  input  logic                                   squash,
  output logic [ISSUE_W-1:0]                     issue_valid,
  output logic [ISSUE_W*XLEN-1:0]                issue_opa,
  output logic [ISSUE_W*XLEN-1:0]                issue_opb,
  output logic [ISSUE_W*$clog2(PRF)-1:0]         issue_dest_prf,
  output logic [ISSUE_W*$clog2(ROB)-1:0]         issue_rob_idx,
  output logic [ISSUE_W*PAYLOAD_W-1:0]           issue_payload,
  output logic [$clog2(RS_SIZE):0]               num_free,
  output logic                                   overflow
);

  localparam int LOGPRF = $clog2(PRF);
  localparam int ROBW   = $clog2(ROB);
  localparam int IDXW   = $clog2(RS_SIZE);
  localparam int NFW    = $clog2(RS_SIZE) + 1;

  typedef struct packed {
    logic [XLEN-1:0]      opa;
    logic [XLEN-1:0]      opb;
    logic                 opa_rdy;
    logic                 opb_rdy;
    logic [LOGPRF-1:0]    dest;
    logic [ROBW-1:0]      rob;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  logic [RS_SIZE-1:0] age_q [RS_SIZE];
  logic [RS_SIZE-1:0] age_d [RS_SIZE];
  logic [RS_SIZE-1:0] valid_q, valid_d;
  logic [RS_SIZE-1:0] cand, leave;
  logic [IDXW:0]      rank [RS_SIZE];

  logic [WAYS-1:0]    alloc_en, drop;
  logic [IDXW-1:0]    alloc_idx [WAYS];
  logic [RS_SIZE-1:0] lower [WAYS];
  logic [RS_SIZE-1:0] taken;
  logic               found;

  entry_t             new_ent;
  logic [NFW-1:0]     occ, num_free_d;

  // Selection: rank = count of older ready entries; rank r drives port r.
  always_comb begin
    cand           = '0;
    leave          = '0;
    issue_valid    = '0;
    issue_opa      = '0;
    issue_opb      = '0;
    issue_dest_prf = '0;
    issue_rob_idx  = '0;
    issue_payload  = '0;
    for (int i = 0; i < RS_SIZE; i++)
      cand[i] = valid_q[i] & ent_q[i].opa_rdy & ent_q[i].opb_rdy;
    for (int i = 0; i < RS_SIZE; i++) begin
      rank[i] = '0;
      for (int j = 0; j < RS_SIZE; j++)
        rank[i] = rank[i] + {{IDXW{1'b0}}, age_q[i][j] & cand[j]};
    end
    for (int p = 0; p < ISSUE_W; p++) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (cand[i] && rank[i] == (IDXW+1)'(p)) begin
          issue_valid[p]                         = 1'b1;
          issue_opa[p*XLEN +: XLEN]              = ent_q[i].opa;
          issue_opb[p*XLEN +: XLEN]              = ent_q[i].opb;
          issue_dest_prf[p*LOGPRF +: LOGPRF]     = ent_q[i].dest;
          issue_rob_idx[p*ROBW +: ROBW]          = ent_q[i].rob;
          issue_payload[p*PAYLOAD_W +: PAYLOAD_W] = ent_q[i].payload;
          leave[i]                               = issue_ready[p] & ~squash;
        end
      end
    end
  end

  // Allocation only sees entries free at start of cycle; lower[w] records earlier ways' picks.
  always_comb begin
    taken    = '0;
    alloc_en = '0;
    drop     = '0;
    found    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      alloc_idx[w] = '0;
      lower[w]     = taken;
      found        = 1'b0;
      if (dispatch_valid[w]) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (!found && !valid_q[i] && !taken[i]) begin
            found        = 1'b1;
            alloc_idx[w] = IDXW'(i);
          end
        end
        if (found) begin
          alloc_en[w]          = 1'b1;
          taken[alloc_idx[w]]  = 1'b1;
        end else begin
          drop[w] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    new_ent = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      age_d[i] = age_q[i];
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int c = 0; c < CDB_W; c++) begin
        if (valid_q[i] && cdb_valid[c]) begin
          if (!ent_q[i].opa_rdy && ent_q[i].opa[LOGPRF-1:0] == cdb_prf_idx[c*LOGPRF +: LOGPRF]) begin
            ent_d[i].opa     = cdb_data[c*XLEN +: XLEN];
            ent_d[i].opa_rdy = 1'b1;
          end
          if (!ent_q[i].opb_rdy && ent_q[i].opb[LOGPRF-1:0] == cdb_prf_idx[c*LOGPRF +: LOGPRF]) begin
            ent_d[i].opb     = cdb_data[c*XLEN +: XLEN];
            ent_d[i].opb_rdy = 1'b1;
          end
        end
      end
    end
    // A leaving entry's column is cleared so a later reuse of that slot reads as younger.
    for (int i = 0; i < RS_SIZE; i++) begin
      if (leave[i]) begin
        valid_d[i] = 1'b0;
        for (int k = 0; k < RS_SIZE; k++)
          age_d[k][i] = 1'b0;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (alloc_en[w]) begin
        new_ent.opa     = opa_in[w*XLEN +: XLEN];
        new_ent.opb     = opb_in[w*XLEN +: XLEN];
        new_ent.opa_rdy = opa_ready_in[w];
        new_ent.opb_rdy = opb_ready_in[w];
        new_ent.dest    = dest_prf_in[w*LOGPRF +: LOGPRF];
        new_ent.rob     = rob_idx_in[w*ROBW +: ROBW];
        new_ent.payload = payload_in[w*PAYLOAD_W +: PAYLOAD_W];
        for (int c = 0; c < CDB_W; c++) begin
          if (cdb_valid[c]) begin
            if (!opa_ready_in[w] && opa_in[w*XLEN +: LOGPRF] == cdb_prf_idx[c*LOGPRF +: LOGPRF]) begin
              new_ent.opa     = cdb_data[c*XLEN +: XLEN];
              new_ent.opa_rdy = 1'b1;
            end
            if (!opb_ready_in[w] && opb_in[w*XLEN +: LOGPRF] == cdb_prf_idx[c*LOGPRF +: LOGPRF]) begin
              new_ent.opb     = cdb_data[c*XLEN +: XLEN];
              new_ent.opb_rdy = 1'b1;
            end
          end
        end
        valid_d[alloc_idx[w]] = 1'b1;
        ent_d[alloc_idx[w]]   = new_ent;
        age_d[alloc_idx[w]]   = (valid_q & ~leave) | lower[w];
      end
    end
    if (squash) begin
      valid_d = '0;
      for (int i = 0; i < RS_SIZE; i++)
        age_d[i] = '0;
    end
    occ = '0;
    for (int i = 0; i < RS_SIZE; i++)
      occ = occ + {{(NFW-1){1'b0}}, valid_d[i]};
    num_free_d = NFW'(RS_SIZE) - occ;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q  <= '0;
      num_free <= NFW'(RS_SIZE);
      overflow <= 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      num_free <= num_free_d;
      overflow <= overflow | ((|drop) & ~squash);
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= ent_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rs_age_issue.sv
// Directed bench for rs_age_issue: reset, oldest-first issue, bypass, stall ordering, overflow, squash.
module tb_rs_age_issue;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [2:0]   dispatch_valid;
  logic [95:0]  opa_in, opb_in;
  logic [2:0]   opa_ready_in, opb_ready_in;
  logic [17:0]  dest_prf_in;
  logic [11:0]  rob_idx_in;
  logic [191:0] payload_in;
  logic [2:0]   cdb_valid;
  logic [17:0]  cdb_prf_idx;
  logic [95:0]  cdb_data;
  logic [2:0]   issue_ready;
  logic         squash;
  logic [2:0]   issue_valid;
  logic [95:0]  issue_opa, issue_opb;
  logic [17:0]  issue_dest_prf;
  logic [11:0]  issue_rob_idx;
  logic [191:0] issue_payload;
  logic [4:0]   num_free;
  logic         overflow;

  int n_chk = 0;
  int n_bad = 0;

  rs_age_issue dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid),
    .opa_in(opa_in), .opb_in(opb_in),
    .opa_ready_in(opa_ready_in), .opb_ready_in(opb_ready_in),
    .dest_prf_in(dest_prf_in), .rob_idx_in(rob_idx_in), .payload_in(payload_in),
    .cdb_valid(cdb_valid), .cdb_prf_idx(cdb_prf_idx), .cdb_data(cdb_data),
    .issue_ready(issue_ready), .squash(squash),
    .issue_valid(issue_valid), .issue_opa(issue_opa), .issue_opb(issue_opb),
    .issue_dest_prf(issue_dest_prf), .issue_rob_idx(issue_rob_idx),
    .issue_payload(issue_payload),
    .num_free(num_free), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in;
    dispatch_valid = '0; opa_in = '0; opb_in = '0;
    opa_ready_in = '0; opb_ready_in = '0;
    dest_prf_in = '0; rob_idx_in = '0; payload_in = '0;
    cdb_valid = '0; cdb_prf_idx = '0; cdb_data = '0;
    squash = 1'b0;
  endtask

  task automatic way(input int w, input logic [31:0] a, input logic ar,
                     input logic [31:0] b, input logic br,
                     input logic [5:0] d, input logic [3:0] r, input logic [63:0] pl);
    dispatch_valid[w]     = 1'b1;
    opa_in[w*32 +: 32]    = a;
    opb_in[w*32 +: 32]    = b;
    opa_ready_in[w]       = ar;
    opb_ready_in[w]       = br;
    dest_prf_in[w*6 +: 6] = d;
    rob_idx_in[w*4 +: 4]  = r;
    payload_in[w*64 +: 64] = pl;
  endtask

  task automatic cdb(input int c, input logic [5:0] t, input logic [31:0] dat);
    cdb_valid[c]           = 1'b1;
    cdb_prf_idx[c*6 +: 6]  = t;
    cdb_data[c*32 +: 32]   = dat;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr_in();
    issue_ready = 3'b000;

    // reset state
    reset = 1'b0;
    tick(); tick();
    chk("rst_free", 64'(num_free), 64'd16);
    chk("rst_valid", 64'(issue_valid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_opa", issue_opa[63:0], 64'd0);
    reset = 1'b1;
    tick();
    chk("rel_free", 64'(num_free), 64'd16);

    // three ready ways issue oldest-first on ports 0/1/2
    for (int w = 0; w < 3; w++)
      way(w, 32'(100 + w), 1'b1, 32'(200 + w), 1'b1, 6'(w + 1), 4'(w), 64'hA0 + 64'(w));
    issue_ready = 3'b111;
    tick();
    clr_in();
    chk("rdy_free", 64'(num_free), 64'd13);
    chk("rdy_valid", 64'(issue_valid), 64'b111);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("rdy_opa%0d", p), 64'(issue_opa[p*32 +: 32]), 64'(100 + p));
      chk($sformatf("rdy_opb%0d", p), 64'(issue_opb[p*32 +: 32]), 64'(200 + p));
      chk($sformatf("rdy_dest%0d", p), 64'(issue_dest_prf[p*6 +: 6]), 64'(p + 1));
      chk($sformatf("rdy_rob%0d", p), 64'(issue_rob_idx[p*4 +: 4]), 64'(p));
      chk($sformatf("rdy_pl%0d", p), issue_payload[p*64 +: 64], 64'hA0 + 64'(p));
    end
    tick();
    chk("rdy_free2", 64'(num_free), 64'd16);
    chk("rdy_valid2", 64'(issue_valid), 64'd0);

    // dispatch bypass on way 2 operand b
    way(0, 32'd1, 1'b1, 32'd2, 1'b1, 6'd1, 4'd0, 64'd0);
    way(1, 32'd3, 1'b1, 32'd4, 1'b1, 6'd2, 4'd1, 64'd0);
    way(2, 32'd5, 1'b1, 32'h2A, 1'b0, 6'd3, 4'd2, 64'd0);
    cdb(1, 6'h2A, 32'hDEAD);
    tick();
    clr_in();
    chk("byp_valid", 64'(issue_valid), 64'b111);
    chk("byp_opb2", 64'(issue_opb[64 +: 32]), 64'hDEAD);
    chk("byp_opa2", 64'(issue_opa[64 +: 32]), 64'd5);
    tick();
    chk("byp_free", 64'(num_free), 64'd16);

    // age ordering under stall
    issue_ready = 3'b000;
    for (int w = 0; w < 3; w++)
      way(w, 32'h300 + 32'(w), 1'b1, 32'h10 + 32'(w), 1'b0, 6'(w), 4'(w), 64'd0);
    tick();
    clr_in();
    for (int w = 0; w < 3; w++)
      way(w, 32'h303 + 32'(w), 1'b1, 32'h13 + 32'(w), 1'b0, 6'(w + 3), 4'(w + 3), 64'd0);
    tick();
    clr_in();
    chk("age_free", 64'(num_free), 64'd10);
    chk("age_none", 64'(issue_valid), 64'd0);
    cdb(0, 6'h15, 32'h1005);
    cdb(1, 6'h13, 32'h1003);
    cdb(2, 6'h11, 32'h1001);
    tick();
    clr_in();
    chk("age_w1_valid", 64'(issue_valid), 64'b111);
    chk("age_w1_p0", 64'(issue_opa[0 +: 32]), 64'h301);
    chk("age_w1_p1", 64'(issue_opa[32 +: 32]), 64'h303);
    chk("age_w1_p2", 64'(issue_opa[64 +: 32]), 64'h305);
    chk("age_w1_opb2", 64'(issue_opb[64 +: 32]), 64'h1005);
    cdb(0, 6'h14, 32'h1004);
    cdb(1, 6'h10, 32'h1000);
    cdb(2, 6'h12, 32'h1002);
    tick();
    clr_in();
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("age_w2_opa%0d", p), 64'(issue_opa[p*32 +: 32]), 64'h300 + 64'(p));
      chk($sformatf("age_w2_opb%0d", p), 64'(issue_opb[p*32 +: 32]), 64'h1000 + 64'(p));
    end
    chk("age_stall_free", 64'(num_free), 64'd10);
    issue_ready = 3'b111;
    tick();
    chk("age_rel_free", 64'(num_free), 64'd13);
    chk("age_rel_valid", 64'(issue_valid), 64'b111);
    for (int p = 0; p < 3; p++)
      chk($sformatf("age_rel_opa%0d", p), 64'(issue_opa[p*32 +: 32]), 64'h303 + 64'(p));
    tick();
    chk("age_end_free", 64'(num_free), 64'd16);
    chk("age_end_valid", 64'(issue_valid), 64'd0);

    // fill to one free slot, then overflow
    issue_ready = 3'b000;
    for (int n = 0; n < 5; n++) begin
      for (int w = 0; w < 3; w++)
        way(w, 32'h3F, 1'b0, 32'd0, 1'b1, 6'd9, 4'd9, 64'd0);
      tick();
      clr_in();
    end
    chk("full_free1", 64'(num_free), 64'd1);
    chk("full_ovf0", 64'(overflow), 64'd0);
    for (int w = 0; w < 3; w++)
      way(w, 32'h500 + 32'(w), 1'b1, 32'd0, 1'b1, 6'd7, 4'd7, 64'd0);
    tick();
    clr_in();
    chk("full_free0", 64'(num_free), 64'd0);
    chk("full_ovf", 64'(overflow), 64'd1);
    chk("full_valid", 64'(issue_valid), 64'b001);
    chk("full_opa0", 64'(issue_opa[0 +: 32]), 64'h500);
    tick();
    chk("full_ovf_hold", 64'(overflow), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    chk("mid_rst_free", 64'(num_free), 64'd16);
    chk("mid_rst_valid", 64'(issue_valid), 64'd0);

    // squash with concurrent wakeup and dispatch
    issue_ready = 3'b111;
    for (int n = 0; n < 8; n++) begin
      way(n % 3, 32'h20 + 32'(n), 1'b0, 32'd7, 1'b1, 6'(n), 4'(n), 64'd0);
      if (n % 3 == 2 || n == 7) begin
        tick();
        clr_in();
      end
    end
    chk("sq_pre_free", 64'(num_free), 64'd8);
    chk("sq_pre_valid", 64'(issue_valid), 64'd0);
    squash = 1'b1;
    cdb(0, 6'h20, 32'h11);
    cdb(1, 6'h21, 32'h22);
    way(0, 32'h99, 1'b1, 32'h98, 1'b1, 6'd1, 4'd1, 64'd0);
    tick();
    clr_in();
    chk("sq_free", 64'(num_free), 64'd16);
    chk("sq_valid", 64'(issue_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++)
        cdb(c, 6'h20 + 6'(k*3 + c), 32'h55);
      tick();
      clr_in();
      chk($sformatf("sq_after%0d", k), 64'(issue_valid), 64'd0);
    end
    chk("sq_end_free", 64'(num_free), 64'd16);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
